// File: rtl/fir_pkg.sv
// Shared constants, FSM state type and signed data types for the serial-MAC FIR filter.
package fir_pkg;

    localparam int unsigned FIR_DATA_WIDTH = 16;
    localparam int unsigned FIR_TAPS       = 64;
    localparam int unsigned FIR_ACC_WIDTH  = 2 * FIR_DATA_WIDTH + $clog2(FIR_TAPS);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StMac
    } state_e;

    typedef logic signed [FIR_DATA_WIDTH-1:0] sample_t;
    typedef logic signed [FIR_ACC_WIDTH-1:0]  acc_t;

endpackage

// File: rtl/fir_serial_mac_if.sv
// Sample-FIFO read side, coefficient write port and filtered-output signals of the FIR.
interface fir_serial_mac_if #(
    parameter int DATA_WIDTH = 16,
    parameter int TAPS       = 64
);

    logic                          fifo_empty;
    logic signed [DATA_WIDTH-1:0]  fifo_data;
    logic                          fifo_rd_en;
    logic                          coef_wr_en;
    logic [$clog2(TAPS)-1:0]       coef_addr;
    logic signed [DATA_WIDTH-1:0]  coef_data;
    logic                          busy;
    logic signed [DATA_WIDTH-1:0]  y_out;
    logic                          y_valid;

    modport slave (
        input  fifo_empty, fifo_data, coef_wr_en, coef_addr, coef_data,
        output fifo_rd_en, busy, y_out, y_valid
    );

    modport master (
        output fifo_empty, fifo_data, coef_wr_en, coef_addr, coef_data,
        input  fifo_rd_en, busy, y_out, y_valid
    );

endinterface

// File: rtl/fir_coef_ram.sv
// TAPS x DATA_WIDTH coefficient register file; writes are ignored while the filter is busy.
module fir_coef_ram #(
    parameter int DATA_WIDTH = 16,
    parameter int TAPS       = 64
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         busy_i,
    input  logic                         wr_en_i,
    input  logic [$clog2(TAPS)-1:0]      wr_addr_i,
    input  logic signed [DATA_WIDTH-1:0] wr_data_i,
    input  logic [$clog2(TAPS)-1:0]      rd_addr_i,
    output logic signed [DATA_WIDTH-1:0] rd_data_o
);

    logic signed [DATA_WIDTH-1:0] coef_q [TAPS];
    logic signed [DATA_WIDTH-1:0] coef_d [TAPS];

    always_comb begin
        coef_d = coef_q;
        if (wr_en_i && !busy_i) begin
            coef_d[wr_addr_i] = wr_data_i;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < TAPS; i++) begin
                coef_q[i] <= '0;
            end
        end else begin
            coef_q <= coef_d;
        end
    end

    assign rd_data_o = coef_q[rd_addr_i];

endmodule

// File: rtl/fir_serial_mac.sv
// Time-multiplexed FIR: one FIFO pop, one LOAD cycle, then TAPS MAC cycles per output.
// Define FIR_SAT_EN to saturate the shifted accumulator instead of wrapping it.
module fir_serial_mac #(
    parameter int DATA_WIDTH = fir_pkg::FIR_DATA_WIDTH,
    parameter int TAPS       = fir_pkg::FIR_TAPS,
    parameter int OUT_SHIFT  = 15
) (
    input logic             clk,
    input logic             rstn,
    fir_serial_mac_if.slave bus
);

    import fir_pkg::*;

    localparam int AW         = $clog2(TAPS);
    localparam int PROD_WIDTH = 2 * DATA_WIDTH;
    localparam int ACC_WIDTH  = PROD_WIDTH + AW;

    state_e                       state_q, state_d;
    logic [AW-1:0]                wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]                k_q, k_d;
    logic [AW-1:0]                rd_idx;
    logic signed [ACC_WIDTH-1:0]  acc_q, acc_d, acc_sum;
    logic signed [DATA_WIDTH-1:0] line_q [TAPS];
    logic signed [DATA_WIDTH-1:0] line_d [TAPS];
    logic signed [DATA_WIDTH-1:0] y_out_q, y_out_d, y_red, coef_rd;
    logic                         y_valid_q, y_valid_d;
    logic signed [PROD_WIDTH-1:0] prod;
    logic                         busy, last_tap;

    assign busy           = (state_q != StIdle);
    assign bus.busy       = busy;
    assign bus.fifo_rd_en = (state_q == StIdle) && !bus.fifo_empty;
    assign bus.y_out      = y_out_q;
    assign bus.y_valid    = y_valid_q;

    fir_coef_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .TAPS      (TAPS)
    ) u_coef_ram (
        .clk      (clk),
        .rstn     (rstn),
        .busy_i   (busy),
        .wr_en_i  (bus.coef_wr_en),
        .wr_addr_i(bus.coef_addr),
        .wr_data_i(bus.coef_data),
        .rd_addr_i(k_q),
        .rd_data_o(coef_rd)
    );

    // wr_ptr_q has already moved past the newest sample by the time MAC runs.
    assign rd_idx   = wr_ptr_q - AW'(1) - k_q;
    assign last_tap = (k_q == AW'(TAPS - 1));
    assign prod     = PROD_WIDTH'(coef_rd) * PROD_WIDTH'(line_q[rd_idx]);
    assign acc_sum  = acc_q + ACC_WIDTH'(prod);

`ifdef FIR_SAT_EN
    localparam logic signed [ACC_WIDTH-1:0] YMax =
        {{(ACC_WIDTH - DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] YMin = ~YMax;

    logic signed [ACC_WIDTH-1:0] acc_shift;

    assign acc_shift = acc_sum >>> OUT_SHIFT;

    always_comb begin
        if (acc_shift > YMax) begin
            y_red = YMax[DATA_WIDTH-1:0];
        end else if (acc_shift < YMin) begin
            y_red = YMin[DATA_WIDTH-1:0];
        end else begin
            y_red = acc_shift[DATA_WIDTH-1:0];
        end
    end
`else
    assign y_red = DATA_WIDTH'(acc_sum >>> OUT_SHIFT);
`endif

    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        k_d       = k_q;
        acc_d     = acc_q;
        y_out_d   = y_out_q;
        y_valid_d = 1'b0;
        line_d    = line_q;
        unique case (state_q)
            StIdle: begin
                if (!bus.fifo_empty) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                line_d[wr_ptr_q] = bus.fifo_data;
                wr_ptr_d         = wr_ptr_q + AW'(1);
                acc_d            = '0;
                k_d              = '0;
                state_d          = StMac;
            end
            StMac: begin
                acc_d = acc_sum;
                k_d   = k_q + AW'(1);
                if (last_tap) begin
                    y_out_d   = y_red;
                    y_valid_d = 1'b1;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= StIdle;
            wr_ptr_q  <= '0;
            k_q       <= '0;
            acc_q     <= '0;
            y_out_q   <= '0;
            y_valid_q <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                line_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            k_q       <= k_d;
            acc_q     <= acc_d;
            y_out_q   <= y_out_d;
            y_valid_q <= y_valid_d;
            line_q    <= line_d;
        end
    end

endmodule

// File: tb/tb_fir_serial_mac.sv
// Bench for fir_serial_mac: FIFO model, convolution reference model, directed and random stimulus.
module tb_fir_serial_mac;

    import fir_pkg::*;

    localparam int DW = FIR_DATA_WIDTH;
    localparam int NT = FIR_TAPS;
    localparam int AW = $clog2(NT);

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic          fifo_empty = 1'b1;
    sample_t       fifo_data  = '0;
    logic          coef_wr_en = 1'b0;
    logic [AW-1:0] coef_addr  = '0;
    sample_t       coef_data  = '0;
    logic          hold_empty = 1'b0;
    logic          pop_req    = 1'b0;
    sample_t       fifo_q [$];

    fir_serial_mac_if #(.DATA_WIDTH(DW), .TAPS(NT)) bus0 ();
    fir_serial_mac_if #(.DATA_WIDTH(DW), .TAPS(NT)) bus15 ();

    assign bus0.fifo_empty  = fifo_empty;
    assign bus0.fifo_data   = fifo_data;
    assign bus0.coef_wr_en  = coef_wr_en;
    assign bus0.coef_addr   = coef_addr;
    assign bus0.coef_data   = coef_data;
    assign bus15.fifo_empty = fifo_empty;
    assign bus15.fifo_data  = fifo_data;
    assign bus15.coef_wr_en = coef_wr_en;
    assign bus15.coef_addr  = coef_addr;
    assign bus15.coef_data  = coef_data;

    fir_serial_mac #(.DATA_WIDTH(DW), .TAPS(NT), .OUT_SHIFT(0)) u_dut0 (
        .clk (clk),
        .rstn(rstn),
        .bus (bus0)
    );

    fir_serial_mac #(.DATA_WIDTH(DW), .TAPS(NT), .OUT_SHIFT(15)) u_dut15 (
        .clk (clk),
        .rstn(rstn),
        .bus (bus15)
    );

    int              tests = 0;
    int              fails = 0;
    int              cnt   = 0;
    bit              vflag = 1'b0;
    int              h    [NT];
    int              hist [NT];
    logic [DW-1:0]   exp0, exp15;
    int              n_valid    = 0;
    int              dut_pulses = 0;
    longint          cyc        = 0;
    logic [DW-1:0]   ylog [$];
    longint          vcyc [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] reduce(input longint acc, input int sh);
        longint s;
        s = acc >>> sh;
`ifdef FIR_SAT_EN
        if (s > 32767) s = 32767;
        else if (s < -32768) s = -32768;
`endif
        return s[DW-1:0];
    endfunction

    function automatic logic [DW-1:0] ylog_at(input int i);
        if (i < ylog.size()) return ylog[i];
        return 'x;
    endfunction

    task automatic model_reset();
        cnt   = 0;
        vflag = 1'b0;
        for (int i = 0; i < NT; i++) begin
            h[i]    = 0;
            hist[i] = 0;
        end
    endtask

    // FIFO: registered data, popped on the edge that ends the rd_en cycle.
    always @(posedge clk) begin
        if (pop_req && fifo_q.size() > 0) begin
            fifo_data <= fifo_q.pop_front();
        end
    end

    // Reference model and per-cycle comparison; inputs settle at the falling edge.
    always @(negedge clk) begin
        bit     exp_busy;
        bit     exp_rd;
        longint acc;
        #1;
        fifo_empty = hold_empty || (fifo_q.size() == 0);
        #1;
        pop_req = bus0.fifo_rd_en && rstn;
        cyc++;
        if (bus0.y_valid) dut_pulses++;
        if (!rstn) begin
            model_reset();
            check("rst_busy", {63'b0, bus0.busy}, 64'd0);
            check("rst_valid", {63'b0, bus0.y_valid | bus15.y_valid}, 64'd0);
            check("rst_y_out", {48'b0, $unsigned(bus0.y_out)}, 64'd0);
        end else begin
            exp_busy = (cnt > 0);
            exp_rd   = !exp_busy && !fifo_empty;
            check("busy0", {63'b0, bus0.busy}, {63'b0, exp_busy});
            check("busy15", {63'b0, bus15.busy}, {63'b0, exp_busy});
            check("rd_en0", {63'b0, bus0.fifo_rd_en}, {63'b0, exp_rd});
            check("rd_en15", {63'b0, bus15.fifo_rd_en}, {63'b0, exp_rd});
            check("y_valid0", {63'b0, bus0.y_valid}, {63'b0, vflag});
            check("y_valid15", {63'b0, bus15.y_valid}, {63'b0, vflag});
            if (vflag) begin
                check("y_out_sh0", {48'b0, $unsigned(bus0.y_out)}, {48'b0, exp0});
                check("y_out_sh15", {48'b0, $unsigned(bus15.y_out)}, {48'b0, exp15});
                ylog.push_back($unsigned(bus0.y_out));
                vcyc.push_back(cyc);
                n_valid++;
            end
            vflag = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) vflag = 1'b1;
            end else begin
                if (coef_wr_en) h[coef_addr] = coef_data;
                if (!fifo_empty) begin
                    for (int i = NT - 1; i > 0; i--) hist[i] = hist[i-1];
                    hist[0] = fifo_q[0];
                    acc = 0;
                    for (int k = 0; k < NT; k++) acc += longint'(h[k]) * longint'(hist[k]);
                    exp0  = reduce(acc, 0);
                    exp15 = reduce(acc, 15);
                    cnt   = NT + 1;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input int addr, input int data);
        coef_wr_en = 1'b1;
        coef_addr  = AW'(addr);
        coef_data  = DW'(data);
        @(negedge clk);
        coef_wr_en = 1'b0;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        tick(3);
        rstn = 1'b1;
        tick(2);
    endtask

    task automatic wait_outputs(input int target, input int budget);
        int b = 0;
        while (n_valid < target && b < budget) begin
            @(negedge clk);
            b++;
        end
        tick(2);
        if (n_valid < target) begin
            tests++;
            fails++;
            $display("FAIL wait_outputs: got %0d outputs, expected %0d", n_valid, target);
        end
    endtask

    task automatic start_test();
        ylog.delete();
        vcyc.delete();
    endtask

    initial begin
        int seen;
        int b;
        int base;
        model_reset();
        tick(3);
        check("reset_y_out", {48'b0, $unsigned(bus0.y_out)}, 64'd0);
        check("reset_y_valid", {63'b0, bus0.y_valid}, 64'd0);
        check("reset_busy", {63'b0, bus0.busy}, 64'd0);
        check("reset_rd_en", {63'b0, bus0.fifo_rd_en}, 64'd0);
        rstn = 1'b1;
        tick(2);

        // Empty FIFO: nothing may move for 200 cycles.
        hold_empty = 1'b1;
        seen = 0;
        repeat (200) begin
            @(negedge clk);
            #3;
            if (bus0.fifo_rd_en || bus0.busy || bus0.y_valid) seen++;
        end
        check("empty_idle", 64'(seen), 64'd0);
        hold_empty = 1'b0;
        tick(1);

        // Impulse response with h[k] = k+1; back-to-back outputs.
        for (int k = 0; k < NT; k++) wr(k, k + 1);
        start_test();
        base = n_valid;
        fifo_q.push_back(DW'(1));
        for (int i = 0; i < NT; i++) fifo_q.push_back('0);
        wait_outputs(base + NT + 1, (NT + 1) * 66 + 200);
        check("impulse_0", {48'b0, ylog_at(0)}, 64'd1);
        check("impulse_1", {48'b0, ylog_at(1)}, 64'd2);
        check("impulse_31", {48'b0, ylog_at(31)}, 64'd32);
        check("impulse_63", {48'b0, ylog_at(63)}, 64'd64);
        check("impulse_64", {48'b0, ylog_at(64)}, 64'd0);
        for (int i = 1; i < vcyc.size(); i++) begin
            check("pulse_spacing", 64'(vcyc[i] - vcyc[i-1]), 64'd66);
        end

        // DC: all h = 1, input 100.
        do_reset();
        for (int k = 0; k < NT; k++) wr(k, 1);
        start_test();
        base = n_valid;
        for (int i = 0; i < NT; i++) fifo_q.push_back(DW'(100));
        wait_outputs(base + NT, NT * 66 + 200);
        check("dc_first", {48'b0, ylog_at(0)}, 64'd100);
        check("dc_second", {48'b0, ylog_at(1)}, 64'd200);
        check("dc_64th", {48'b0, ylog_at(63)}, 64'd6400);

        // Full-scale input and coefficients.
        do_reset();
        for (int k = 0; k < NT; k++) wr(k, 32'h7FFF);
        start_test();
        base = n_valid;
        for (int i = 0; i < NT; i++) fifo_q.push_back(DW'(16'h7FFF));
        wait_outputs(base + NT, NT * 66 + 200);
`ifdef FIR_SAT_EN
        check("sat_first", {48'b0, ylog_at(0)}, 64'h7FFF);
        check("sat_64th", {48'b0, ylog_at(63)}, 64'h7FFF);
`else
        check("wrap_first", {48'b0, ylog_at(0)}, 64'h0001);
        check("wrap_64th", {48'b0, ylog_at(63)}, 64'h0040);
`endif

        // Coefficient write during MAC is dropped.
        do_reset();
        wr(0, 3);
        start_test();
        base = n_valid;
        fifo_q.push_back(DW'(7));
        tick(10);
        wr(0, 100);
        wait_outputs(base + 1, 200);
        fifo_q.push_back(DW'(1));
        wait_outputs(base + 2, 200);
        check("busy_write_1", {48'b0, ylog_at(0)}, 64'd21);
        check("busy_write_2", {48'b0, ylog_at(1)}, 64'd3);

        // Reset in the middle of MAC (tap 30).
        do_reset();
        wr(0, 9);
        fifo_q.push_back(DW'(4));
        b = 0;
        while (cnt != 34 && b < 200) begin
            @(negedge clk);
            b++;
        end
        check("reached_mac30", 64'(cnt), 64'd34);
        rstn = 1'b0;
        tick(2);
        rstn = 1'b1;
        base = dut_pulses;
        tick(100);
        check("no_valid_after_reset", 64'(dut_pulses - base), 64'd0);
        wr(0, 2);
        wr(1, 3);
        start_test();
        base = n_valid;
        fifo_q.push_back(DW'(5));
        wait_outputs(base + 1, 200);
        check("after_reset_y", {48'b0, ylog_at(0)}, 64'd10);

        // Random traffic, random coefficients, random (often dropped) writes.
        do_reset();
        for (int k = 0; k < NT; k++) wr(k, int'($urandom_range(0, 65535)));
        repeat (3000) begin
            if (($urandom % 4) == 0 && fifo_q.size() < 4) fifo_q.push_back(DW'($urandom));
            hold_empty = (($urandom % 8) == 0);
            coef_wr_en = (($urandom % 16) == 0);
            coef_addr  = AW'($urandom);
            coef_data  = DW'($urandom);
            @(negedge clk);
        end
        hold_empty = 1'b0;
        coef_wr_en = 1'b0;
        b = 0;
        while ((fifo_q.size() > 0 || cnt > 0 || vflag) && b < 600) begin
            @(negedge clk);
            b++;
        end
        tick(3);
        check("random_drained", 64'(fifo_q.size() + cnt), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
